// File: rtl/button_conditioner.sv
// button_conditioner: sync + debounce FSM for one active-low pushbutton.
// Optional hold detector enabled by BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
  parameter int unsigned CNT_WIDTH = 24,
  parameter logic [CNT_WIDTH-1:0] DEBOUNCE_COUNT = 24'd120000,
  parameter logic [CNT_WIDTH-1:0] LONG_COUNT = 24'd12000000
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam logic [1:0] S_RELEASED     = 2'd0;
  localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] S_PRESSED      = 2'd2;
  localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DB_LAST = DEBOUNCE_COUNT - ONE;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic pressed_s;

  logic [1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic level_q, level_d;
  logic press_q, press_d;
  logic rel_q, rel_d;

  // Two-stage synchroniser; idle (released) button reads as 1.
  always_comb begin
    s1_d = btn_in;
    s2_d = s1_q;
  end

  // Synchroniser flops; reset to the idle level so no press is seen.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign pressed_s = ~s2_q;

  // Debounce FSM: a change is accepted only after it holds
  // for DEBOUNCE_COUNT consecutive samples in a wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RELEASED: begin
        if (pressed_s) begin
          state_d = S_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (!pressed_s) begin
          state_d = S_RELEASED;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_PRESSED;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_PRESSED: begin
        if (!pressed_s) begin
          state_d = S_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (pressed_s) begin
          state_d = S_PRESSED;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_RELEASED;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= S_RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the transition being taken so they appear
  // on the same edge the FSM accepts the change.
  always_comb begin
    level_d = (state_d == S_PRESSED) ||
              (state_d == S_RELEASE_WAIT);
    press_d = (state_q == S_PRESS_WAIT) &&
              (state_d == S_PRESSED);
    rel_d   = (state_q == S_RELEASE_WAIT) &&
              (state_d == S_RELEASED);
  end

  // Registered outputs; no combinational path from btn_in.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN

  localparam logic [CNT_WIDTH-1:0] L_LAST = LONG_COUNT - ONE;

  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic hold_act;
  logic long_q, long_d;

  // Hold counter runs while the button is debounced-pressed
  // (release bounces included), cleared otherwise, and parks
  // at LONG_COUNT so it can fire only once per press.
  always_comb begin
    hold_act = (state_q == S_PRESSED) ||
               (state_q == S_RELEASE_WAIT);
    hold_d   = '0;
    if (hold_act) begin
      if (hold_q != LONG_COUNT) begin
        hold_d = hold_q + ONE;
      end else begin
        hold_d = hold_q;
      end
    end
    long_d = hold_act && level_d && (hold_q == L_LAST);
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;

`else

  logic [CNT_WIDTH-1:0] unused_long_count;

  assign unused_long_count = LONG_COUNT;
  assign long_press = 1'b0;

`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: vector table, directed corners, random vs model.
// Expects long_press only when BUTTON_CONDITIONER_LONG_PRESS_EN is set.
module tb_button_conditioner;

  localparam int D = 8;
  localparam int L = 32;
`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
  localparam int LP = 1;
`else
  localparam int LP = 0;
`endif

  logic clk = 1'b0;
  logic rst_btn;
  logic btn_in;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .CNT_WIDTH(24),
    .DEBOUNCE_COUNT(24'd8),
    .LONG_COUNT(24'd32)
  ) dut (
    .clk(clk),
    .rst_btn(rst_btn),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_press(long_press)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: debounced level flips once the synchronised
  // input (btn two edges ago) has disagreed with it for D+1
  // consecutive samples; long fires on the L-th held edge.
  bit m_s1 = 1'b1;
  bit m_s2 = 1'b1;
  bit m_level = 1'b0;
  bit m_press = 1'b0;
  bit m_rel = 1'b0;
  bit m_long = 1'b0;
  int run = 0;
  int held = 0;

  initial begin
    bit ps;
    bit old;
    forever begin
      @(posedge clk or negedge rst_btn);
      if (!rst_btn) begin
        m_s1 = 1'b1; m_s2 = 1'b1;
        m_level = 1'b0; m_press = 1'b0;
        m_rel = 1'b0; m_long = 1'b0;
        run = 0; held = 0;
      end else begin
        ps = !m_s2;
        m_s2 = m_s1;
        m_s1 = btn_in;
        old = m_level;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
        if (ps != m_level) begin
          run++;
          if (run == D + 1) begin
            m_level = ps;
            run = 0;
            if (ps) m_press = 1'b1;
            else m_rel = 1'b1;
          end
        end else begin
          run = 0;
        end
        if (old && m_level) begin
          held++;
          if (held == L && LP == 1) m_long = 1'b1;
        end else begin
          held = 0;
        end
      end
    end
  end

  // Continuous comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_level", btn_level, m_level);
      chk("m_press", press_pulse, m_press);
      chk("m_release", release_pulse, m_rel);
      chk("m_long", long_press, m_long);
      chk("pulse_excl", press_pulse & release_pulse, 0);
    end
  end

  typedef struct {
    bit rst;
    bit btn;
    int cycles;
    int lvl;
    int np;
    int nr;
    int nl;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  initial begin
    int np, nr, nl, len;
    rst_btn = 1'b0;
    btn_in  = 1'b0;
    tbl[0]  = '{1'b0, 1'b0, 5,  0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 4,  0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 5,  0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b1, 1,  0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 15, 1, 1, 0, 0};
    tbl[5]  = '{1'b1, 1'b1, 1,  1, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 5,  1, 0, 0, 0};
    tbl[7]  = '{1'b1, 1'b1, 15, 0, 0, 1, 0};
    tbl[8]  = '{1'b1, 1'b0, 10, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1,  1, 1, 0, 0};
    tbl[10] = '{1'b1, 1'b1, 10, 1, 0, 0, 0};
    tbl[11] = '{1'b1, 1'b1, 1,  0, 0, 1, 0};
    tbl[12] = '{1'b1, 1'b0, 60, 1, 1, 0, LP};
    tbl[13] = '{1'b1, 1'b1, 15, 0, 0, 1, 0};
    tbl[14] = '{1'b1, 1'b0, 32, 1, 1, 0, 0};
    tbl[15] = '{1'b1, 1'b1, 15, 0, 0, 1, 0};
    tbl[16] = '{1'b1, 1'b0, 33, 1, 1, 0, 0};
    tbl[17] = '{1'b1, 1'b1, 15, 0, 0, 1, LP};

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      #1;
      rst_btn = tbl[i].rst;
      btn_in  = tbl[i].btn;
      np = 0; nr = 0; nl = 0;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        @(negedge clk);
        np += int'(press_pulse);
        nr += int'(release_pulse);
        nl += int'(long_press);
      end
      chk($sformatf("vec%0d_level", i), btn_level, tbl[i].lvl);
      chk($sformatf("vec%0d_press", i), np, tbl[i].np);
      chk($sformatf("vec%0d_release", i), nr, tbl[i].nr);
      chk($sformatf("vec%0d_long", i), nl, tbl[i].nl);
    end

    // Exact press/release latency of D+3 edges.
    #1 btn_in = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      chk($sformatf("lat_press_lvl_e%0d", e), btn_level, e >= D + 3);
      chk($sformatf("lat_press_pls_e%0d", e), press_pulse, e == D + 3);
    end
    #1 btn_in = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      chk($sformatf("lat_rel_lvl_e%0d", e), btn_level, e < D + 3);
      chk($sformatf("lat_rel_pls_e%0d", e), release_pulse, e == D + 3);
    end

    // Reset in the middle of a press wait discards the press.
    #1 btn_in = 1'b0;
    repeat (7) @(negedge clk);
    #1 rst_btn = 1'b0;
    #1;
    chk("rst_mid_level", btn_level, 0);
    chk("rst_mid_press", press_pulse, 0);
    @(negedge clk);
    #1 rst_btn = 1'b1;
    np = 0;
    repeat (D + 2) begin
      @(negedge clk);
      np += int'(press_pulse);
    end
    chk("rst_mid_no_early_press", np, 0);
    @(negedge clk);
    chk("rst_mid_new_press", press_pulse, 1);
    chk("rst_mid_new_level", btn_level, 1);
    #1 btn_in = 1'b1;
    repeat (15) @(negedge clk);

    // Random bouncy stimulus with occasional long holds and resets.
    for (int r = 0; r < 250; r++) begin
      #1;
      rst_btn = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
      btn_in  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        len = int'($urandom_range(30, 70));
      else
        len = int'($urandom_range(1, 12));
      repeat (len) @(negedge clk);
    end

    #1 rst_btn = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
